// File: rtl/ula_sequenciador.sv
// Multi-cycle sequencer for the external 8-bit ALU: single-pass ops, shift-add MUL and
// restoring DIV built by iterating the same ALU, with valid/ready request and response.
module ula_sequenciador #(
    parameter int unsigned        LARGURA       = 8,
    parameter logic [LARGURA-1:0] QUOC_DIV_ZERO = 8'hFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valido,
    output logic               req_pronto,
    input  logic [3:0]         req_op,
    input  logic [LARGURA-1:0] req_a,
    input  logic [LARGURA-1:0] req_b,
    output logic               resp_valido,
    input  logic               resp_pronto,
    output logic [LARGURA-1:0] resultado,
    output logic [LARGURA-1:0] resto,
    output logic               erro,
    output logic               ocupado,
    output logic [LARGURA-1:0] ula_entrada1,
    output logic [LARGURA-1:0] ula_entrada2,
    output logic [2:0]         ula_sinal,
    input  logic [LARGURA-1:0] ula_saida
);

    localparam logic [2:0] UlaAdd = 3'd2;
    localparam logic [2:0] UlaSub = 3'd3;
    localparam logic [2:0] UlaSlt = 3'd4;

    typedef enum logic [2:0] {
        StOcioso, StSimples, StMul, StDivCmp, StDivSub, StResposta
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [2:0]         op_q, op_d;
    logic [LARGURA-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]         i_q, i_d;
    logic [LARGURA-1:0] acc_q, acc_d;    // P for MUL, partial remainder R for DIV
    logic [LARGURA-1:0] quoc_q, quoc_d;
    logic               lt_q, lt_d;
    logic [LARGURA-1:0] resultado_q, resultado_d, resto_q, resto_d;
    logic               erro_q, erro_d;
    logic [LARGURA-1:0] t_div;

    // Shifted partial remainder; acc_q[7] marks that the true value is >= 256.
    assign t_div = {acc_q[LARGURA-2:0], a_q[i_q]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= StOcioso;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            i_q         <= '0;
            acc_q       <= '0;
            quoc_q      <= '0;
            lt_q        <= 1'b0;
            resultado_q <= '0;
            resto_q     <= '0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            i_q         <= i_d;
            acc_q       <= acc_d;
            quoc_q      <= quoc_d;
            lt_q        <= lt_d;
            resultado_q <= resultado_d;
            resto_q     <= resto_d;
            erro_q      <= erro_d;
        end
    end

    always_comb begin
        estado_d     = estado_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        i_d          = i_q;
        acc_d        = acc_q;
        quoc_d       = quoc_q;
        lt_d         = lt_q;
        resultado_d  = resultado_q;
        resto_d      = resto_q;
        erro_d       = erro_q;
        ula_entrada1 = '0;
        ula_entrada2 = '0;
        ula_sinal    = 3'd0;

        unique case (estado_q)
            StOcioso: begin
                if (req_valido) begin
                    op_d   = req_op[2:0];
                    a_d    = req_a;
                    b_d    = req_b;
                    i_d    = 3'd7;
                    acc_d  = '0;
                    quoc_d = '0;
                    erro_d = 1'b0;
                    if (req_op <= 4'd4) begin
                        estado_d = StSimples;
                    end else if (req_op == 4'd5) begin
                        estado_d = StMul;
                    end else if (req_op == 4'd6 && req_b != '0) begin
                        estado_d = StDivCmp;
                    end else if (req_op == 4'd6) begin
                        estado_d    = StResposta;
                        resultado_d = QUOC_DIV_ZERO;
                        resto_d     = req_a;
                        erro_d      = 1'b1;
                    end else begin
                        estado_d    = StResposta;
                        resultado_d = '0;
                        resto_d     = '0;
                        erro_d      = 1'b1;
                    end
                end
            end
            StSimples: begin
                ula_sinal    = op_q;
                ula_entrada1 = a_q;
                ula_entrada2 = b_q;
                resultado_d  = ula_saida;
                resto_d      = '0;
                estado_d     = StResposta;
            end
            StMul: begin
                ula_sinal    = UlaAdd;
                ula_entrada1 = {acc_q[LARGURA-2:0], 1'b0};
                ula_entrada2 = b_q[i_q] ? a_q : '0;
                acc_d        = ula_saida;
                if (i_q == 3'd0) begin
                    resultado_d = ula_saida;
                    resto_d     = '0;
                    estado_d    = StResposta;
                end else begin
                    i_d = i_q - 3'd1;
                end
            end
            StDivCmp: begin
                ula_sinal    = UlaSlt;
                ula_entrada1 = t_div;
                ula_entrada2 = b_q;
                lt_d         = ula_saida[0] & ~acc_q[LARGURA-1];
                estado_d     = StDivSub;
            end
            StDivSub: begin
                ula_sinal    = UlaSub;
                ula_entrada1 = t_div;
                ula_entrada2 = b_q;
                // Mod-256 difference is exact even when the true T exceeds 255.
                if (!lt_q) begin
                    acc_d       = ula_saida;
                    quoc_d[i_q] = 1'b1;
                end else begin
                    acc_d       = t_div;
                    quoc_d[i_q] = 1'b0;
                end
                if (i_q == 3'd0) begin
                    resultado_d = quoc_d;
                    resto_d     = acc_d;
                    estado_d    = StResposta;
                end else begin
                    i_d      = i_q - 3'd1;
                    estado_d = StDivCmp;
                end
            end
            StResposta: begin
                if (resp_pronto) begin
                    erro_d   = 1'b0;
                    estado_d = StOcioso;
                end
            end
            default: estado_d = StOcioso;
        endcase
    end

    assign req_pronto  = (estado_q == StOcioso);
    assign ocupado     = (estado_q != StOcioso);
    assign resp_valido = (estado_q == StResposta);
    assign resultado   = resultado_q;
    assign resto       = resto_q;
    assign erro        = erro_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Self-checking bench for ula_sequenciador: behavioural ALU, directed scenarios and
// randomized operations compared against a plain-arithmetic reference model.
module tb_ula_sequenciador;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valido, req_pronto;
    logic [3:0] req_op;
    logic [7:0] req_a, req_b;
    logic       resp_valido, resp_pronto;
    logic [7:0] resultado, resto;
    logic       erro, ocupado;
    logic [7:0] ula_entrada1, ula_entrada2, ula_saida;
    logic [2:0] ula_sinal;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    ula_sequenciador dut (
        .clock       (clock),
        .reset       (reset),
        .req_valido  (req_valido),
        .req_pronto  (req_pronto),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valido (resp_valido),
        .resp_pronto (resp_pronto),
        .resultado   (resultado),
        .resto       (resto),
        .erro        (erro),
        .ocupado     (ocupado),
        .ula_entrada1(ula_entrada1),
        .ula_entrada2(ula_entrada2),
        .ula_sinal   (ula_sinal),
        .ula_saida   (ula_saida)
    );

    // External ALU
    always_comb begin
        ula_saida = 8'd0;
        case (ula_sinal)
            3'd0: ula_saida = ula_entrada1 & ula_entrada2;
            3'd1: ula_saida = ula_entrada1 | ula_entrada2;
            3'd2: ula_saida = ula_entrada1 + ula_entrada2;
            3'd3: ula_saida = ula_entrada1 - ula_entrada2;
            3'd4: ula_saida = (ula_entrada1 < ula_entrada2) ? 8'd1 : 8'd0;
            default: ula_saida = 8'd0;
        endcase
    end

    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic [7:0] rem, output logic err,
                         output int lat);
        int prod;
        rem = 8'd0; err = 1'b0; lat = 2; res = 8'd0;
        case (op)
            4'd0: res = a & b;
            4'd1: res = a | b;
            4'd2: res = 8'((int'(a) + int'(b)) % 256);
            4'd3: res = 8'((int'(a) - int'(b) + 256) % 256);
            4'd4: res = (a < b) ? 8'd1 : 8'd0;
            4'd5: begin prod = int'(a) * int'(b); res = 8'(prod % 256); lat = 9; end
            4'd6: begin
                if (b == 0) begin res = 8'hFF; rem = a; err = 1'b1; lat = 1; end
                else begin res = a / b; rem = a % b; lat = 17; end
            end
            default: begin err = 1'b1; lat = 1; end
        endcase
    endtask

    // Drives one request, waits (bounded) for the response, then completes the handshake.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold, output int lat, output logic [7:0] res,
                          output logic [7:0] rem, output logic err, output int add_cnt);
        lat = -1; res = 8'hxx; rem = 8'hxx; err = 1'bx; add_cnt = 0;
        @(negedge clock);
        req_valido = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clock);
        #1;
        req_valido = 1'b0;
        req_op = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (resp_valido) begin lat = k; break; end
            if (ula_sinal == 3'd2) add_cnt++;
        end
        if (lat < 0) return;
        res = resultado; rem = resto; err = erro;
        repeat (hold) @(negedge clock);
        resp_pronto = 1'b1;
        @(posedge clock);
        #1 resp_pronto = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; req_valido = 1'b0; req_op = 4'd0; req_a = 8'd0; req_b = 8'd0;
        resp_pronto = 1'b0;
        repeat (3) @(negedge clock);
        n_chk++; if (resp_valido !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valido got %b want 0", resp_valido); end
        n_chk++; if ({resultado, resto, erro} !== 17'd0) begin n_fail++; $display("FAIL rst_outputs got %h/%h/%b want 0/0/0", resultado, resto, erro); end
        n_chk++; if ({ula_entrada1, ula_entrada2, ula_sinal} !== 19'd0) begin n_fail++; $display("FAIL rst_ula got %h/%h/%h want 0", ula_entrada1, ula_entrada2, ula_sinal); end
        n_chk++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL rst_ocupado got %b want 0", ocupado); end
        reset = 1'b1;
        @(negedge clock);
        n_chk++; if (req_pronto !== 1'b1) begin n_fail++; $display("FAIL rst_req_pronto got %b want 1", req_pronto); end
    endtask

    task automatic test_simple;
        int lat, ac; logic [7:0] r, m; logic e;
        run_op(4'd2, 8'd200, 8'd100, 0, lat, r, m, e, ac);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL add_lat got %0d want 2", lat); end
        n_chk++; if ({r, m, e} !== {8'h2C, 8'h00, 1'b0}) begin n_fail++; $display("FAIL add_res got %h/%h/%b want 2c/00/0", r, m, e); end
        run_op(4'd4, 8'd3, 8'd9, 0, lat, r, m, e, ac);
        n_chk++; if (r !== 8'd1) begin n_fail++; $display("FAIL slt_res got %h want 01", r); end
    endtask

    task automatic test_mul;
        int lat, ac; logic [7:0] r, m; logic e;
        run_op(4'd5, 8'd13, 8'd11, 0, lat, r, m, e, ac);
        n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL mul_lat got %0d want 9", lat); end
        n_chk++; if (r !== 8'd143) begin n_fail++; $display("FAIL mul13x11 got %0d want 143", r); end
        n_chk++; if (ac !== 8) begin n_fail++; $display("FAIL mul_add_cycles got %0d want 8", ac); end
        run_op(4'd5, 8'd20, 8'd20, 0, lat, r, m, e, ac);
        n_chk++; if ({r, m, e} !== {8'h90, 8'h00, 1'b0}) begin n_fail++; $display("FAIL mul20x20 got %h/%h/%b want 90/00/0", r, m, e); end
    endtask

    task automatic test_div;
        int lat, ac; logic [7:0] r, m; logic e;
        run_op(4'd6, 8'd200, 8'd7, 0, lat, r, m, e, ac);
        n_chk++; if (lat !== 17) begin n_fail++; $display("FAIL div_lat got %0d want 17", lat); end
        n_chk++; if ({r, m} !== {8'd28, 8'd4}) begin n_fail++; $display("FAIL div200_7 got %0d r%0d want 28 r4", r, m); end
        run_op(4'd6, 8'd255, 8'd200, 0, lat, r, m, e, ac);
        n_chk++; if ({r, m, e} !== {8'd1, 8'd55, 1'b0}) begin n_fail++; $display("FAIL div255_200 got %0d r%0d e%b want 1 r55 e0", r, m, e); end
    endtask

    task automatic test_errors;
        int lat, ac; logic [7:0] r, m; logic e;
        run_op(4'd6, 8'd50, 8'd0, 0, lat, r, m, e, ac);
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL divz_lat got %0d want 1", lat); end
        n_chk++; if ({r, m, e} !== {8'hFF, 8'd50, 1'b1}) begin n_fail++; $display("FAIL divz_res got %h/%0d/%b want ff/50/1", r, m, e); end
        run_op(4'd9, 8'd12, 8'd34, 0, lat, r, m, e, ac);
        n_chk++; if ({lat, r, e} !== {32'd1, 8'd0, 1'b1}) begin n_fail++; $display("FAIL badop got lat%0d %h e%b want lat1 00 e1", lat, r, e); end
        run_op(4'd2, 8'd1, 8'd2, 0, lat, r, m, e, ac);
        n_chk++; if ({r, e} !== {8'd3, 1'b0}) begin n_fail++; $display("FAIL add_after_err got %h e%b want 03 e0", r, e); end
    endtask

    task automatic test_backpressure;
        int lat = -1;
        @(negedge clock);
        req_valido = 1'b1; req_op = 4'd2; req_a = 8'd5; req_b = 8'd6;
        @(posedge clock);
        #1 req_valido = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (resp_valido) begin lat = k; break; end
        end
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL bp_lat got %0d want 2", lat); end
        req_valido = 1'b1; req_op = 4'd3; req_a = 8'd99; req_b = 8'd1;
        for (int h = 0; h < 5; h++) begin
            @(negedge clock);
            n_chk++; if ({resp_valido, req_pronto, resultado, erro} !== {1'b1, 1'b0, 8'd11, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold%0d got v%b p%b %h e%b want v1 p0 0b e0", h, resp_valido, req_pronto, resultado, erro);
            end
        end
        resp_pronto = 1'b1;
        @(posedge clock);
        #1 resp_pronto = 1'b0; req_valido = 1'b0;
        @(negedge clock);
        n_chk++; if ({resp_valido, ocupado, req_pronto} !== 3'b001) begin n_fail++; $display("FAIL bp_release got v%b o%b p%b want 001", resp_valido, ocupado, req_pronto); end
        repeat (3) @(negedge clock);
        n_chk++; if ({resp_valido, ocupado} !== 2'b00) begin n_fail++; $display("FAIL bp_ignored_req got v%b o%b want 00", resp_valido, ocupado); end
    endtask

    task automatic test_reset_mid_div;
        int lat, ac; logic [7:0] r, m; logic e;
        @(negedge clock);
        req_valido = 1'b1; req_op = 4'd6; req_a = 8'd200; req_b = 8'd3;
        @(posedge clock);
        #1 req_valido = 1'b0;
        repeat (5) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        n_chk++; if ({resp_valido, ocupado} !== 2'b00) begin n_fail++; $display("FAIL midrst_ctrl got v%b o%b want 00", resp_valido, ocupado); end
        n_chk++; if ({resultado, resto, erro, ula_entrada1, ula_entrada2, ula_sinal} !== 36'd0) begin
            n_fail++; $display("FAIL midrst_outs got %h/%h/%b/%h/%h/%h want 0", resultado, resto, erro, ula_entrada1, ula_entrada2, ula_sinal);
        end
        @(negedge clock);
        reset = 1'b1;
        run_op(4'd6, 8'd100, 8'd10, 0, lat, r, m, e, ac);
        n_chk++; if ({lat, r, m, e} !== {32'd17, 8'd10, 8'd0, 1'b0}) begin n_fail++; $display("FAIL div_after_rst got lat%0d %0d r%0d e%b want lat17 10 r0 e0", lat, r, m, e); end
    endtask

    task automatic test_random;
        int lat, ac, elat; logic [7:0] r, m, er, em, a, b; logic e, ee; logic [3:0] op;
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            model(op, a, b, er, em, ee, elat);
            run_op(op, a, b, $urandom_range(0, 2), lat, r, m, e, ac);
            n_chk++; if ({lat, r, m, e} !== {elat, er, em, ee}) begin
                n_fail++; $display("FAIL rnd%0d op%0d a%0d b%0d got lat%0d %h/%h/%b want lat%0d %h/%h/%b", n, op, a, b, lat, r, m, e, elat, er, em, ee);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_simple();
        test_mul();
        test_div();
        test_errors();
        test_backpressure();
        test_reset_mid_div();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
